// File: rtl/serial_twos_deser.sv
`default_nettype none
// ============================================================================
// Module   : serial_twos_deser
// Purpose  : Bit-serial two's-complement frame receiver. Assembles LSB-first
//            WIDTH-bit frames, optionally re-applies the serial complement
//            rule, and presents raw/recovered words on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module serial_twos_deser #(
  parameter int WIDTH  = 8,
  parameter bit NEGATE = 1'b1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             s_start,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out_raw,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  output logic             busy,
  output logic             err_abort,
  output logic             err_ovr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    C_LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    C_ONE      = CW'(1);
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             found, found_nx;
  logic [WIDTH-1:0] raw_sh, raw_nx;
  logic [WIDTH-1:0] rec_sh, rec_nx;
  logic             first_bit;
  logic             found_eff;
  logic             rec_bit;
  logic             complete;
  logic             abort;
  logic             load_ok;
  logic             drop;
  logic [WIDTH-1:0] word_nx;
  logic             ovf_nx;

  // Next-state: frame sequencing, bit placement and serial negation.
  // The shift registers are written by position so that raw_nx/rec_nx hold
  // the complete word on the edge that samples the last bit.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    found_nx  = found;
    raw_nx    = raw_sh;
    rec_nx    = rec_sh;
    complete  = 1'b0;
    abort     = 1'b0;
    first_bit = s_en && s_start;
    found_eff = first_bit ? 1'b0 : found;
    rec_bit   = s_in ^ found_eff;

    if (first_bit) begin
      raw_nx    = '0;
      rec_nx    = '0;
      raw_nx[0] = s_in;
      rec_nx[0] = rec_bit;
      cnt_nx    = C_ONE;
      state_nx  = SHIFT;
      abort     = (state == SHIFT);
      found_nx  = s_in;
    end else if (s_en && state == SHIFT) begin
      raw_nx[cnt] = s_in;
      rec_nx[cnt] = rec_bit;
      found_nx    = found_eff | s_in;
      if (cnt == C_LAST) begin
        complete = 1'b1;
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + C_ONE;
      end
    end

    word_nx = NEGATE ? rec_nx : raw_nx;
    ovf_nx  = NEGATE && (raw_nx == C_MOST_NEG);
    load_ok = complete && (!out_valid || out_ready);
    drop    = complete && out_valid && !out_ready;
  end

  // Frame assembly state register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state  <= IDLE;
      cnt    <= '0;
      found  <= 1'b0;
      raw_sh <= '0;
      rec_sh <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      found  <= found_nx;
      raw_sh <= raw_nx;
      rec_sh <= rec_nx;
    end
  end

  // Output word register: load on completion unless a word is stuck pending.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      out_raw   <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_ok) begin
      out_raw   <= raw_nx;
      out_data  <= word_nx;
      out_ovf   <= ovf_nx;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      err_abort <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      if (abort)        err_abort <= 1'b1;
      else if (clr_err) err_abort <= 1'b0;
      if (drop)         err_ovr   <= 1'b1;
      else if (clr_err) err_ovr   <= 1'b0;
    end
  end

  // Busy mirrors the registered state, so it stays free of input paths.
  always_comb begin
    busy = (state == SHIFT);
  end

endmodule
`default_nettype wire
